tri_raster: RTL and testbench

TRI_RASTER -- requirements
Module: tri_raster

---
 rtl/tri_raster.sv | 248 ++++++++++++++++++++++++
 tb/tb_tri_raster.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tri_raster.sv
// ---------------------------------------------------------------------------
// tri_raster
//   Rasterizes one triangle per start request. The vertices are latched in
//   IDLE. SETUP builds the clamped bounding box and the signed area. EDGE
//   evaluates the three edge functions at the top-left corner of the box.
//   SCAN then walks the box in raster order, one candidate per cycle, and
//   updates the edge functions with adds and subtracts only. Each covered
//   pixel is handed downstream over a valid/ready pair.
//
// Ports
//   clk                 single clock, rising edge
//   reset               asynchronous, active-high
//   start               rasterize the presented vertices (sampled in IDLE)
//   v1x..v3y [15:0]     unsigned vertex pixel coordinates
//   busy                high in every state except IDLE
//   done                one-cycle completion pulse (FIN state)
//   pix_valid           pix_x/pix_y hold a covered pixel
//   pix_ready           downstream accepts the pixel
//   pix_x, pix_y [15:0] covered pixel coordinate (registered)
// ---------------------------------------------------------------------------
module tri_raster #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] v1x,
  input  logic [15:0] v1y,
  input  logic [15:0] v2x,
  input  logic [15:0] v2y,
  input  logic [15:0] v3x,
  input  logic [15:0] v3y,
  output logic        busy,
  output logic        done,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y
);

  typedef enum logic [2:0] {IDLE, SETUP, EDGE, SCAN, FIN} state_t;

  localparam logic [15:0] XLIM = 16'(SCREEN_W - 1);
  localparam logic [15:0] YLIM = 16'(SCREEN_H - 1);
  localparam logic [16:0] W17  = 17'(SCREEN_W);
  localparam logic [16:0] H17  = 17'(SCREEN_H);

  // Zero-extend a coordinate into the 34-bit signed arithmetic domain.
  function automatic logic signed [33:0] ext(input logic [15:0] v);
    return $signed({18'd0, v});
  endfunction

  function automatic logic [15:0] min3(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c);
    logic [15:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [15:0] max3(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c);
    logic [15:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  state_t r_state;
  state_t w_next;

  logic [15:0] r_vx [3];
  logic [15:0] r_vy [3];

  logic [15:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic [15:0] r_cx, r_cy;
  logic        r_exhausted;   // every candidate has been evaluated

  logic        r_pix_valid;
  logic [15:0] r_pix_x, r_pix_y;

  logic [15:0]        w_xmin, w_ymin, w_xmax_raw, w_ymax_raw;
  logic               w_offscreen;
  logic signed [33:0] w_area;
  logic [2:0]         w_ge0, w_le0;
  logic               w_covered;
  logic               w_stall, w_adv, w_row_end, w_last;

  // ---------------- setup arithmetic ----------------
  assign w_xmin     = min3(r_vx[0], r_vx[1], r_vx[2]);
  assign w_ymin     = min3(r_vy[0], r_vy[1], r_vy[2]);
  assign w_xmax_raw = max3(r_vx[0], r_vx[1], r_vx[2]);
  assign w_ymax_raw = max3(r_vy[0], r_vy[1], r_vy[2]);

  assign w_offscreen = ({1'b0, w_xmin} >= W17) || ({1'b0, w_ymin} >= H17);

  assign w_area = (ext(r_vx[1]) - ext(r_vx[0])) * (ext(r_vy[2]) - ext(r_vy[0]))
                - (ext(r_vy[1]) - ext(r_vy[0])) * (ext(r_vx[2]) - ext(r_vx[0]));

  // ---------------- scan control ----------------
  assign w_stall   = r_pix_valid & ~pix_ready;
  assign w_adv     = (r_state == SCAN) & ~w_stall & ~r_exhausted;
  assign w_row_end = (r_cx == r_xmax);
  assign w_last    = w_row_end & (r_cy == r_ymax);
  // Accepting both sign patterns makes the block winding-agnostic; zero on an
  // edge satisfies both tests so edge pixels are always included.
  assign w_covered = (&w_ge0) | (&w_le0);

  // ---------------- state machine ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = SETUP;
      SETUP: w_next = (w_area == 34'sd0 || w_offscreen) ? FIN : EDGE;
      EDGE:  w_next = SCAN;
      // Leave only once the final candidate's pixel (if any) has transferred.
      SCAN:  if (r_exhausted && !w_stall) w_next = FIN;
      FIN:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ---------------- vertex capture ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        r_vx[k] <= '0;
        r_vy[k] <= '0;
      end
    end else if (r_state == IDLE && start) begin
      r_vx[0] <= v1x;  r_vy[0] <= v1y;
      r_vx[1] <= v2x;  r_vy[1] <= v2y;
      r_vx[2] <= v3x;  r_vy[2] <= v3y;
    end
  end

  // ---------------- bounding box ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xmin <= '0;
      r_xmax <= '0;
      r_ymin <= '0;
      r_ymax <= '0;
    end else if (r_state == SETUP) begin
      r_xmin <= w_xmin;
      r_ymin <= w_ymin;
      r_xmax <= (w_xmax_raw > XLIM) ? XLIM : w_xmax_raw;
      r_ymax <= (w_ymax_raw > YLIM) ? YLIM : w_ymax_raw;
    end
  end

  // ---------------- candidate counters ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cx        <= '0;
      r_cy        <= '0;
      r_exhausted <= 1'b0;
    end else if (r_state == EDGE) begin
      r_cx        <= r_xmin;
      r_cy        <= r_ymin;
      r_exhausted <= 1'b0;
    end else if (w_adv) begin
      // Counters stop on the last candidate so they never step past the box.
      if (w_last) begin
        r_exhausted <= 1'b1;
      end else if (w_row_end) begin
        r_cx <= r_xmin;
        r_cy <= r_cy + 16'd1;
      end else begin
        r_cx <= r_cx + 16'd1;
      end
    end
  end

  // ---------------- edge functions ----------------
  // Edge gi runs from vertex gi to vertex (gi+1)%3. r_e tracks the current
  // candidate; r_er holds the value at the start of the current row so a row
  // wrap needs only one subtract instead of undoing the whole row.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      localparam int NB = (gi + 1) % 3;
      logic signed [33:0] r_dx, r_dy, r_e, r_er, w_e0;

      assign w_e0 = (ext(r_xmin) - ext(r_vx[gi])) * r_dy
                  - (ext(r_ymin) - ext(r_vy[gi])) * r_dx;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_dx <= '0;
          r_dy <= '0;
          r_e  <= '0;
          r_er <= '0;
        end else if (r_state == SETUP) begin
          r_dx <= ext(r_vx[NB]) - ext(r_vx[gi]);
          r_dy <= ext(r_vy[NB]) - ext(r_vy[gi]);
        end else if (r_state == EDGE) begin
          r_e  <= w_e0;
          r_er <= w_e0;
        end else if (w_adv && !w_last) begin
          if (w_row_end) begin
            r_e  <= r_er - r_dx;
            r_er <= r_er - r_dx;
          end else begin
            r_e  <= r_e + r_dy;
          end
        end
      end

      assign w_ge0[gi] = ~r_e[33];
      assign w_le0[gi] = r_e[33] | (r_e == 34'sd0);
    end
  endgenerate

  // ---------------- pixel output register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
    end else if (r_state == SCAN) begin
      if (!w_stall) begin
        if (!r_exhausted) begin
          r_pix_valid <= w_covered;
          if (w_covered) begin
            r_pix_x <= r_cx;
            r_pix_y <= r_cy;
          end
        end else begin
          r_pix_valid <= 1'b0;
        end
      end
    end else begin
      r_pix_valid <= 1'b0;
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FIN);
  assign pix_valid = r_pix_valid;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;

endmodule

// File: tb/tb_tri_raster.sv
module tb_tri_raster;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] v1x, v1y, v2x, v2y, v3x, v3y;
  logic        busy, done, pix_valid, pix_ready;
  logic [15:0] pix_x, pix_y;

  tri_raster #(.SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .v1x       (v1x),
    .v1y       (v1y),
    .v2x       (v2x),
    .v2y       (v2y),
    .v3x       (v3x),
    .v3y       (v3y),
    .busy      (busy),
    .done      (done),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y)
  );

  always #5 clk = ~clk;

  // Expected order for triangle (0,0),(3,0),(0,3): every pixel with x+y<=3.
  localparam int T10_X [10] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
  localparam int T10_Y [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};

  int n_checks;
  int n_pass;

  // Results of the most recent run_tri call.
  logic [15:0] px [64];
  logic [15:0] py [64];
  int          n_pix;
  int          done_cnt;
  int          done_at;
  int          first_at;
  bit          aborted;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_pix(input string tag, input int idx, input int ex, input int ey);
    logic [31:0] obs;
    logic [31:0] exp;
    obs = {px[idx], py[idx]};
    exp = {16'(ex), 16'(ey)};
    check_eq($sformatf("%s_pix%0d", tag, idx), obs, exp);
  endtask

  // Present a triangle, collect transfers until done (plus a few idle cycles).
  // stall_en: hold pix_ready low for 5 cycles when pixel (2,0) is offered.
  // reset_after: >0 pulses reset right after that many transfers.
  task automatic run_tri(input logic [15:0] ax, input logic [15:0] ay,
                         input logic [15:0] bx, input logic [15:0] by,
                         input logic [15:0] cx, input logic [15:0] cy,
                         input bit stall_en, input int reset_after);
    int stall_left;
    bit stall_used;
    stall_left = 0;
    stall_used = 0;
    n_pix = 0; done_cnt = 0; done_at = -1; first_at = -1; aborted = 0;
    @(negedge clk);
    v1x = ax; v1y = ay; v2x = bx; v2y = by; v3x = cx; v3y = cy;
    start = 1; pix_ready = 1;
    @(negedge clk);
    // Scramble the inputs: only the captured copy may be used from here on.
    start = 0;
    v1x = 16'd9; v1y = 16'd1; v2x = 16'd50; v2y = 16'd60; v3x = 16'd7; v3y = 16'd90;
    for (int i = 1; i <= 300; i++) begin
      if (pix_valid && first_at < 0) first_at = i;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (stall_en && !stall_used && pix_valid && pix_x == 16'd2 && pix_y == 16'd0) begin
        stall_used = 1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        pix_ready = 0;
        check_eq("stall_valid", {31'd0, pix_valid}, 32'd1);
        check_eq("stall_x", {16'd0, pix_x}, 32'd2);
        check_eq("stall_y", {16'd0, pix_y}, 32'd0);
        stall_left--;
      end else begin
        pix_ready = 1;
      end
      if (pix_valid && pix_ready) begin
        if (n_pix < 64) begin
          px[n_pix] = pix_x;
          py[n_pix] = pix_y;
        end
        n_pix++;
        $display("pixel %0d: (%0d,%0d) at cycle %0d", n_pix, pix_x, pix_y, i);
        if (reset_after > 0 && n_pix == reset_after) begin
          @(posedge clk);
          #1 reset = 1;
          #1;
          check_eq("rst_busy", {31'd0, busy}, 32'd0);
          check_eq("rst_done", {31'd0, done}, 32'd0);
          check_eq("rst_valid", {31'd0, pix_valid}, 32'd0);
          check_eq("rst_pixxy", {pix_x, pix_y}, 32'd0);
          #2 reset = 0;
          aborted = 1;
          break;
        end
      end
      if (done_at >= 0 && i >= done_at + 3) break;
      @(negedge clk);
    end
    check_eq("no_timeout", {31'd0, (done_at >= 0 || aborted)}, 32'd1);
    if (!aborted) check_eq("idle_after", {31'd0, busy}, 32'd0);
    $display("run (%0d,%0d),(%0d,%0d),(%0d,%0d): %0d pixels, %0d done pulses",
             ax, ay, bx, by, cx, cy, n_pix, done_cnt);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clk = 0; reset = 1; start = 0; pix_ready = 1;
    v1x = 0; v1y = 0; v2x = 0; v2y = 0; v3x = 0; v3y = 0;

    repeat (2) @(negedge clk);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_done", {31'd0, done}, 32'd0);
    check_eq("reset_valid", {31'd0, pix_valid}, 32'd0);
    check_eq("reset_pixxy", {pix_x, pix_y}, 32'd0);
    reset = 0;

    // Basic triangle, full throughput.
    run_tri(16'd0, 16'd0, 16'd3, 16'd0, 16'd0, 16'd3, 0, 0);
    check_eq("tri_count", n_pix, 32'd10);
    for (int k = 0; k < 10; k++) check_pix("tri", k, T10_X[k], T10_Y[k]);
    check_eq("tri_done", done_cnt, 32'd1);
    check_eq("tri_latency_ok", {31'd0, first_at >= 3}, 32'd1);

    // Reversed winding.
    run_tri(16'd0, 16'd0, 16'd0, 16'd3, 16'd3, 16'd0, 0, 0);
    check_eq("rev_count", n_pix, 32'd10);
    for (int k = 0; k < 10; k++) check_pix("rev", k, T10_X[k], T10_Y[k]);
    check_eq("rev_done", done_cnt, 32'd1);

    // Degenerate triangle: no pixels, done two cycles after start.
    run_tri(16'd0, 16'd0, 16'd2, 16'd2, 16'd4, 16'd4, 0, 0);
    check_eq("col_count", n_pix, 32'd0);
    check_eq("col_done_cycle", done_at, 32'd2);
    check_eq("col_done", done_cnt, 32'd1);

    // Entirely off-screen.
    run_tri(16'd700, 16'd10, 16'd800, 16'd10, 16'd700, 16'd100, 0, 0);
    check_eq("off_count", n_pix, 32'd0);
    check_eq("off_done", done_cnt, 32'd1);

    // Back-pressure at pixel (2,0).
    run_tri(16'd0, 16'd0, 16'd3, 16'd0, 16'd0, 16'd3, 1, 0);
    check_eq("stl_count", n_pix, 32'd10);
    for (int k = 0; k < 10; k++) check_pix("stl", k, T10_X[k], T10_Y[k]);
    check_eq("stl_done", done_cnt, 32'd1);

    // Reset after the 4th transfer, then a fresh small triangle.
    run_tri(16'd0, 16'd0, 16'd3, 16'd0, 16'd0, 16'd3, 0, 4);
    check_eq("abt_count", n_pix, 32'd4);
    check_eq("abt_done", done_cnt, 32'd0);
    run_tri(16'd1, 16'd1, 16'd2, 16'd1, 16'd1, 16'd2, 0, 0);
    check_eq("small_count", n_pix, 32'd3);
    check_pix("small", 0, 1, 1);
    check_pix("small", 1, 2, 1);
    check_pix("small", 2, 1, 2);
    check_eq("small_done", done_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
